seq_div_26by13: RTL

//  Iterative radix-2 restoring unsigned divider, the inverse of the 13x13 multiplier leaf.
//  - Input: 2W-bit dividend y and W-bit divisor b. Output: quotient a = y / b and remainder r = y % b.
//  - Used to check partial products in the FP64 datapath and as the mantissa-divide leaf.
//  - One quotient bit is produced per clock, with valid/ready handshakes on both sides.

---
 rtl/seq_div_26by13.sv | 113 +++++++++++
 1 files changed

// File: rtl/seq_div_26by13.sv
// Iterative radix-2 restoring divider: 2W-bit dividend by W-bit divisor, one quotient bit per clock.
// Divide-by-zero and quotient overflow are flagged and finish in a single cycle.
module seq_div_26by13 #(
    parameter int W = 13
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2*W-1:0]   y,
    input  logic [W-1:0]     b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     q,
    output logic [W-1:0]     r,
    output logic             dz,
    output logic             ovf,
    output logic [1:0]       fsm_state
);

    localparam int CW = $clog2(W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [W:0]      rem;
    logic [W-1:0]    dnd;
    logic [W-1:0]    dvs;
    logic [CW-1:0]   cnt;

    logic [W:0]      t;
    logic [W:0]      diff;
    logic            ge;
    logic [W:0]      rem_next;

    // One shift/compare/subtract step; rem stays below dvs so rem[W] is always 0.
    always_comb begin
        t        = {rem[W-1:0], dnd[W-1]};
        diff     = t - {1'b0, dvs};
        ge       = (t >= {1'b0, dvs});
        rem_next = ge ? diff : t;
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign fsm_state = state;

    // Handshakes: a transfer happens on an edge where valid and ready are both 1;
    // valid/data are sampled only then, and the result is held until out_ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            rem   <= '0;
            dnd   <= '0;
            dvs   <= '0;
            cnt   <= '0;
            q     <= '0;
            r     <= '0;
            dz    <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (b == '0) begin
                            q     <= '1;
                            r     <= y[W-1:0];
                            dz    <= 1'b1;
                            ovf   <= 1'b0;
                            state <= DONE;
                        end else if (y[2*W-1:W] >= b) begin
                            q     <= '1;
                            r     <= y[W-1:0];
                            dz    <= 1'b0;
                            ovf   <= 1'b1;
                            state <= DONE;
                        end else begin
                            rem   <= {1'b0, y[2*W-1:W]};
                            dnd   <= y[W-1:0];
                            dvs   <= b;
                            cnt   <= '0;
                            q     <= '0;
                            dz    <= 1'b0;
                            ovf   <= 1'b0;
                            state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    rem <= rem_next;
                    dnd <= {dnd[W-2:0], 1'b0};
                    q   <= {q[W-2:0], ge};
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(W - 1)) begin
                        r     <= rem_next[W-1:0];
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
